imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate-extension unit for the MIPS datapath.
- Generalises the fixed 16-to-32 sign extender to configurable widths. Adds four extension modes: sign, zero, LUI-upper and branch-offset shift.
- Holds results in a 2-entry skid buffer with valid/ready handshakes on both sides, so it can sit between decode and execute stages as the datapath is pipelined.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W.
- OUT_W, 32, extended output width.
- SHIFT_BR, 2, left shift applied in branch mode; legal range 0..OUT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  extended immediate.
- out_trunc  output  1  branch-mode result not representable in OUT_W; 0 in all other modes.

Behaviour:
- Input transfer occurs on a rising edge with in_valid & in_ready. Output transfer occurs with out_valid & out_ready.
- Arithmetic is evaluated on the input side and the result is stored. The mode is not re-evaluated later.
  - sign: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - zero: fill bits OUT_W-1..IN_W with 0.
  - upper: {in_imm, (OUT_W-IN_W) zeros}; equals in_imm when IN_W==OUT_W.
  - branch: sign-extend, then shift left by SHIFT_BR and keep the low OUT_W bits. Zeros are shifted in.
    - trunc=1 iff the sign-extended value × 2^SHIFT_BR lies outside the signed OUT_W range.
    - Equivalently, trunc=1 iff the top SHIFT_BR+1 bits of the (OUT_W+SHIFT_BR)-bit product are not all equal.
- Storage is a main register (drives out_*) plus one skid register.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Transitions:
  - EMPTY: accept -> ONE. The accepted beat is visible on out_* the next cycle (latency 1).
  - ONE:
    - accept and no output transfer -> FULL; the new beat goes to skid.
    - accept and output transfer -> ONE; the new beat replaces main.
    - output transfer only -> EMPTY.
    - otherwise hold.
  - FULL:
    - output transfer -> ONE; skid moves to main.
    - otherwise hold. No accept is possible.
- in_ready = ~skid_valid & ~reset, driven from registered state only, with no combinational path from out_ready. It is therefore 0 in FULL.
- Order is strictly FIFO. No beat is ever dropped or duplicated.
- out_data and out_trunc hold stable while out_valid=1 and out_ready=0.
- Reset (synchronous, any state including FULL mid-stall):
  - Next edge: out_valid=0, out_data=0, out_trunc=0, skid cleared, state EMPTY.
  - in_ready=0 while reset is high, and 1 in the first cycle after.
  - Beats presented during reset are discarded.
- in_mode and in_imm are ignored when in_valid=0.
- X on in_imm is never propagated into stored state unless accepted.

Test Plan:
- Defaults, out_ready=1, in_imm=0x8004 in each mode on consecutive cycles -> outputs 0xFFFF8004, 0x00008004, 0x80040000, 0xFFFE0010, one per cycle with latency 1. trunc=0 for all four.
- in_imm=0x7FFF, sign -> 0x00007FFF; branch -> 0x0001FFFC; zero -> 0x00007FFF.
- out_ready=0, stream A=0x0001, B=0x0002, C=0x0003 (sign) -> A and B accepted, in_ready=0 while C is held. Raise out_ready -> A, B, C emerge in order with no gaps. out_data stays 0x00000001 throughout the stall.
- Reset asserted in FULL (two beats stored) -> next cycle out_valid=0, out_data=0, in_ready=0 during reset and 1 after. The next beat 0x0005 sign emerges as 0x00000005.
- IN_W=16, OUT_W=16, SHIFT_BR=2, branch:
  - in_imm=0x4000 -> out_data=0x0000, trunc=1.
  - 0xF000 -> 0xC000, trunc=0.
  - 0x1FFF -> 0x7FFC, trunc=0.
- IN_W=8, OUT_W=16, SHIFT_BR=2, in_imm=0x80:
  - sign -> 0xFF80.
  - zero -> 0x0080.
  - upper -> 0x8000.
  - branch -> 0xFE00, trunc=0.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe.
//   Upstream (decode side):  in_valid, in_ready, in_imm[IN_W], in_mode[2]
//   Downstream (execute side): out_valid, out_ready, out_data[OUT_W], out_trunc
// The master modport is the environment (producer and consumer); the slave
// modport is the extension unit itself.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_trunc;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_trunc
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_trunc
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension unit with a 2-entry skid buffer.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : imm_extend_pipe_if.slave (valid/ready in, valid/ready out)
// Modes: 00 sign, 01 zero, 10 upper (imm placed in the top bits),
//        11 branch (sign-extend then shift left by SHIFT_BR, flag overflow).
//
// state    | meaning
// ---------+-------------------------------------
// ST_EMPTY | main register invalid
// ST_ONE   | main valid, skid empty
// ST_FULL  | main and skid both valid
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHIFT_BR = 2
) (
    input  logic                clk,
    input  logic                reset,
    imm_extend_pipe_if.slave    bus
);
    localparam int PW = OUT_W + SHIFT_BR;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t           state_q;
    logic [OUT_W-1:0] main_data_q;
    logic             main_trunc_q;
    logic [OUT_W-1:0] skid_data_q;
    logic             skid_trunc_q;

    logic [OUT_W-1:0] res_data_d;
    logic             res_trunc_d;
    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_zero;
    logic [PW-1:0]    prod;
    logic [SHIFT_BR:0] prod_top;

    logic accept;
    logic deliver;

    // Extension is evaluated once on the input side; the stored result
    // never depends on in_mode again.
    always_comb begin
        ext_sign    = OUT_W'($signed(bus.in_imm));
        ext_zero    = OUT_W'(bus.in_imm);
        prod        = PW'($signed(bus.in_imm)) << SHIFT_BR;
        // Product fits in OUT_W signed iff its top SHIFT_BR+1 bits agree.
        prod_top    = prod[PW-1:OUT_W-1];
        res_data_d  = ext_sign;
        res_trunc_d = 1'b0;
        case (bus.in_mode)
            2'b00: res_data_d = ext_sign;
            2'b01: res_data_d = ext_zero;
            2'b10: res_data_d = ext_zero << (OUT_W - IN_W);
            default: begin
                res_data_d  = prod[OUT_W-1:0];
                res_trunc_d = ~((&prod_top) | ~(|prod_top));
            end
        endcase
    end

    // in_ready depends only on registered state and reset, never on out_ready.
    assign bus.in_ready  = (state_q != ST_FULL) & ~reset;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = main_data_q;
    assign bus.out_trunc = main_trunc_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_trunc_q <= 1'b0;
            skid_data_q  <= '0;
            skid_trunc_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_q  <= res_data_d;
                        main_trunc_q <= res_trunc_d;
                        state_q      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !deliver) begin
                        skid_data_q  <= res_data_d;
                        skid_trunc_q <= res_trunc_d;
                        state_q      <= ST_FULL;
                    end else if (accept && deliver) begin
                        main_data_q  <= res_data_d;
                        main_trunc_q <= res_trunc_d;
                    end else if (deliver) begin
                        state_q      <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        main_data_q  <= skid_data_q;
                        main_trunc_q <= skid_trunc_q;
                        state_q      <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three configurations (16->32, 16->16, 8->16,
// all with SHIFT_BR=2), directed cases plus randomized traffic checked
// against an arithmetic reference model and an ordering scoreboard.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus0 ();
    imm_extend_pipe_if #(.IN_W(16), .OUT_W(16)) bus1 ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) bus2 ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT_BR(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT_BR(2)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    imm_extend_pipe #(.IN_W(8),  .OUT_W(16), .SHIFT_BR(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

    // Reference: plain integer arithmetic. Returns {trunc, data[31:0]}.
    function automatic logic [32:0] ref_ext(int in_w, int out_w, int sh, longint imm, int mode);
        longint v, m, p, d;
        logic   t;
        m = longint'(1) << out_w;
        v = imm;
        if (imm >= (longint'(1) << (in_w - 1))) v = imm - (longint'(1) << in_w);
        t = 1'b0;
        case (mode)
            0: p = v;
            1: p = imm;
            2: p = imm * (longint'(1) << (out_w - in_w));
            default: begin
                p = v * (longint'(1) << sh);
                t = (p < -(m / 2)) || (p > (m / 2 - 1));
            end
        endcase
        d = ((p % m) + m) % m;
        return {t, 32'(d)};
    endfunction

    task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for configuration 0: FIFO order, no drops/duplicates,
    // values from the model, stability while stalled.
    logic [32:0] exp_q[$];
    logic        hold_chk = 1'b0;
    logic [32:0] hold_val = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) chk("stall_hold", {bus0.out_trunc, bus0.out_data}, hold_val);
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $error("FAIL unexpected_beat observed=%h expected=none", {bus0.out_trunc, bus0.out_data});
                end else begin
                    chk("scoreboard", {bus0.out_trunc, bus0.out_data}, exp_q.pop_front());
                end
            end
            if (bus0.in_valid && bus0.in_ready)
                exp_q.push_back(ref_ext(16, 32, 2, longint'(bus0.in_imm), int'(bus0.in_mode)));
            hold_chk = bus0.out_valid && !bus0.out_ready;
            hold_val = {bus0.out_trunc, bus0.out_data};
        end
    end

    task automatic drive0(logic v, logic [15:0] imm, logic [1:0] mode);
        bus0.in_valid = v;
        bus0.in_imm   = imm;
        bus0.in_mode  = mode;
    endtask

    initial begin
        logic [31:0] t1_exp [4];
        logic [31:0] t2_exp [3];
        logic [1:0]  t2_mode [3];
        logic [15:0] d1_imm [3];
        logic [16:0] d1_exp [3];
        logic [15:0] d2_exp [4];
        logic [32:0] r1, r2;
        int          k;

        t1_exp  = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};
        t2_exp  = '{32'h00007FFF, 32'h0001FFFC, 32'h00007FFF};
        t2_mode = '{2'b00, 2'b11, 2'b01};
        d1_imm  = '{16'h4000, 16'hF000, 16'h1FFF};
        d1_exp  = '{{1'b1, 16'h0000}, {1'b0, 16'hC000}, {1'b0, 16'h7FFC}};
        d2_exp  = '{16'hFF80, 16'h0080, 16'h8000, 16'hFE00};

        reset = 1'b1;
        drive0(1'b0, 16'h0, 2'b00);
        bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_imm = '0; bus1.in_mode = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_imm = '0; bus2.in_mode = '0; bus2.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", {32'h0, bus0.in_ready}, 33'h0);
        chk("rst_out_valid", {32'h0, bus0.out_valid}, 33'h0);
        chk("rst_out", {bus0.out_trunc, bus0.out_data}, 33'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", {32'h0, bus0.in_ready}, 33'h1);

        // 0x8004 in each mode, back to back, latency 1
        for (int m = 0; m < 4; m++) begin
            drive0(1'b1, 16'h8004, 2'(m));
            tick();
            chk("t1_valid", {32'h0, bus0.out_valid}, 33'h1);
            chk("t1_data", {bus0.out_trunc, bus0.out_data}, {1'b0, t1_exp[m]});
        end
        // 0x7FFF sign / branch / zero
        for (int m = 0; m < 3; m++) begin
            drive0(1'b1, 16'h7FFF, t2_mode[m]);
            tick();
            chk("t2_data", {bus0.out_trunc, bus0.out_data}, {1'b0, t2_exp[m]});
        end
        drive0(1'b0, 16'h0, 2'b00);
        tick();
        chk("t2_drained", {32'h0, bus0.out_valid}, 33'h0);

        // Stall: A, B accepted, C held off, then drain in order
        bus0.out_ready = 1'b0;
        drive0(1'b1, 16'h0001, 2'b00); tick();
        drive0(1'b1, 16'h0002, 2'b00); tick();
        drive0(1'b1, 16'h0003, 2'b00); tick();
        chk("stall_in_ready", {32'h0, bus0.in_ready}, 33'h0);
        chk("stall_data", {bus0.out_trunc, bus0.out_data}, 33'h1);
        tick();
        chk("stall_in_ready2", {32'h0, bus0.in_ready}, 33'h0);
        chk("stall_data2", {bus0.out_trunc, bus0.out_data}, 33'h1);
        bus0.out_ready = 1'b1;
        tick();
        chk("drain_B", {bus0.out_valid, bus0.out_data}, {1'b1, 32'h2});
        tick();
        drive0(1'b0, 16'h0, 2'b00);
        chk("drain_C", {bus0.out_valid, bus0.out_data}, {1'b1, 32'h3});
        tick();
        chk("drain_empty", {32'h0, bus0.out_valid}, 33'h0);

        // Reset while FULL
        bus0.out_ready = 1'b0;
        drive0(1'b1, 16'h0011, 2'b00); tick();
        drive0(1'b1, 16'h0022, 2'b00); tick();
        chk("full_in_ready", {32'h0, bus0.in_ready}, 33'h0);
        drive0(1'b1, 16'h0033, 2'b00);
        reset = 1'b1;
        tick();
        chk("rstfull_out", {bus0.out_valid, bus0.out_data}, 33'h0);
        chk("rstfull_in_ready", {32'h0, bus0.in_ready}, 33'h0);
        tick();
        reset = 1'b0;
        drive0(1'b0, 16'h0, 2'b00);
        tick();
        chk("rstfull_after", {bus0.out_valid, 31'h0, bus0.in_ready}, 33'h1);
        bus0.out_ready = 1'b1;
        drive0(1'b1, 16'h0005, 2'b00);
        tick();
        chk("rstfull_next", {bus0.out_valid, bus0.out_data}, {1'b1, 32'h5});
        drive0(1'b0, 16'h0, 2'b00);
        tick();

        // Randomized traffic on configuration 0, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus0.out_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 65)
                drive0(1'b1, 16'($urandom), 2'($urandom));
            else begin
                bus0.in_valid = 1'b0;
                bus0.in_imm   = 'x;
                bus0.in_mode  = 'x;
            end
            tick();
        end
        drive0(1'b0, 16'h0, 2'b00);
        bus0.out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        chk("final_drain", {1'b0, 32'(exp_q.size())}, 33'h0);

        // Configuration 1: 16 -> 16 branch mode
        for (int i = 0; i < 3; i++) begin
            bus1.in_valid = 1'b1; bus1.in_imm = d1_imm[i]; bus1.in_mode = 2'b11;
            tick();
            chk("cfg1_dir", {16'h0, bus1.out_trunc, bus1.out_data}, {16'h0, d1_exp[i]});
        end
        // Configuration 2: 8 -> 16, 0x80 in each mode
        for (int m = 0; m < 4; m++) begin
            bus2.in_valid = 1'b1; bus2.in_imm = 8'h80; bus2.in_mode = 2'(m);
            tick();
            chk("cfg2_dir", {bus2.out_trunc, 16'h0, bus2.out_data}, {17'h0, d2_exp[m]});
        end
        // Random back-to-back beats on configurations 1 and 2
        for (int i = 0; i < 60; i++) begin
            bus1.in_imm = 16'($urandom); bus1.in_mode = 2'($urandom);
            bus2.in_imm = 8'($urandom);  bus2.in_mode = 2'($urandom);
            r1 = ref_ext(16, 16, 2, longint'(bus1.in_imm), int'(bus1.in_mode));
            r2 = ref_ext(8, 16, 2, longint'(bus2.in_imm), int'(bus2.in_mode));
            tick();
            chk("cfg1_rand", {bus1.out_trunc, 16'h0, bus1.out_data}, r1);
            chk("cfg2_rand", {bus2.out_trunc, 16'h0, bus2.out_data}, r2);
        end
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
